// File: rtl/keys_pkg.sv
// Shared types and helpers for the key front end.
package keys_pkg;

    // Per-channel hold tracking: released, held before the long threshold, held past it.
    typedef enum logic [1:0] {
        REL  = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } hold_state_e;

    // Counter width large enough to hold the largest of the three terminal counts.
    function automatic int unsigned clog2_max3(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/keys_debounce_ch.sv
// One key channel: mask + 2-flop sync, debounce counter, press/release pulses,
// and the hold FSM producing long-press and auto-repeat pulses.
module keys_debounce_ch
    import keys_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 100000,
    parameter int unsigned LONG_CNT   = 50000000,
    parameter int unsigned REPEAT_CNT = 10000000,
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned REPEAT_EN  = 1,
    parameter int unsigned CNT_W      = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw_i,
    input  logic key_mask_i,
    output logic key_level_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_pulse_o,
    output logic repeat_pulse_o
);

    localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic REP_ON  = (REPEAT_EN != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] STABLE_TERM = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CNT - 1);

    logic             sync1_q, sync2_q;
    logic             pressed_s;
    logic             level_q, level_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             commit;
    logic             press_q, rel_q;
    hold_state_e      state_q;
    logic [CNT_W-1:0] hcnt_q;
    logic             long_q, rep_q;

    // Two-flop synchroniser; masking ahead of it makes a cleared mask look
    // exactly like a raw release, with the full sync + debounce latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= REL_LVL;
            sync2_q <= REL_LVL;
        end else begin
            sync1_q <= key_mask_i ? key_raw_i : REL_LVL;
            sync2_q <= sync1_q;
        end
    end

    // Normalise to 1 = pressed.
    always_comb begin
        pressed_s = sync2_q ^ REL_LVL;
    end

    // Debounce next-state: count consecutive disagreeing cycles, commit at the terminal count.
    always_comb begin
        level_d = level_q;
        dcnt_d  = '0;
        commit  = 1'b0;
        if (pressed_s != level_q) begin
            if (dcnt_q == STABLE_TERM) begin
                commit  = 1'b1;
                level_d = pressed_s;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // Debounced level and the edge pulses, registered together so they coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
            dcnt_q  <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
            press_q <= commit & pressed_s;
            rel_q   <= commit & ~pressed_s;
        end
    end

    // Hold FSM; a release commit takes priority over a coincident long/repeat expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REL;
            hcnt_q  <= '0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            long_q <= 1'b0;
            rep_q  <= 1'b0;
            case (state_q)
                REL: begin
                    hcnt_q <= '0;
                    if (commit && pressed_s) state_q <= HELD;
                end
                HELD: begin
                    if (commit) begin
                        state_q <= REL;
                        hcnt_q  <= '0;
                    end else if (hcnt_q == LONG_TERM) begin
                        state_q <= LONG;
                        long_q  <= 1'b1;
                        hcnt_q  <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                LONG: begin
                    if (commit) begin
                        state_q <= REL;
                        hcnt_q  <= '0;
                    end else if (hcnt_q == REPEAT_TERM) begin
                        rep_q  <= REP_ON;
                        hcnt_q <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= REL;
                    hcnt_q  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        key_level_o     = level_q;
        press_pulse_o   = press_q;
        release_pulse_o = rel_q;
        long_pulse_o    = long_q;
        repeat_pulse_o  = rep_q;
    end

endmodule

// File: rtl/keys_debounce_array.sv
// N-channel key front end: one independent debounce/hold channel per key,
// plus a registered "any key pressed" flag.
module keys_debounce_array
    import keys_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = 5,
    parameter int unsigned STABLE_CNT = 100000,
    parameter int unsigned LONG_CNT   = 50000000,
    parameter int unsigned REPEAT_CNT = 10000000,
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned REPEAT_EN  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_KEYS-1:0] key_mask,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse,
    output logic                any_pressed
);

    localparam int unsigned CNT_W = clog2_max3(STABLE_CNT, LONG_CNT, REPEAT_CNT);

    logic any_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        keys_debounce_ch #(
            .STABLE_CNT (STABLE_CNT),
            .LONG_CNT   (LONG_CNT),
            .REPEAT_CNT (REPEAT_CNT),
            .ACTIVE_LOW (ACTIVE_LOW),
            .REPEAT_EN  (REPEAT_EN),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk             (clk),
            .reset           (reset),
            .key_raw_i       (key_raw[g]),
            .key_mask_i      (key_mask[g]),
            .key_level_o     (key_level[g]),
            .press_pulse_o   (press_pulse[g]),
            .release_pulse_o (release_pulse[g]),
            .long_pulse_o    (long_pulse[g]),
            .repeat_pulse_o  (repeat_pulse[g])
        );
    end

    // Registered OR of the debounced levels (one cycle behind key_level).
    always_ff @(posedge clk) begin
        if (reset) any_q <= 1'b0;
        else       any_q <= |key_level;
    end

    always_comb begin
        any_pressed = any_q;
    end

endmodule

// File: tb/tb_keys_debounce_array.sv
// Bench for keys_debounce_array: two instances (repeat enabled / disabled) share
// stimulus and are compared each cycle against an elapsed-time reference model.
module tb_keys_debounce_array;

    localparam int STABLE = 4;
    localparam int LONG   = 20;
    localparam int REPEAT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] key_raw, key_mask;
    logic [4:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
    logic [4:0] lvl_b, prs_b, rel_b, lng_b, rep_b;
    logic       any_a, any_b;
    logic [25:0] got_a, got_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    keys_debounce_array #(
        .NUM_KEYS(5), .STABLE_CNT(STABLE), .LONG_CNT(LONG), .REPEAT_CNT(REPEAT),
        .ACTIVE_LOW(1), .REPEAT_EN(1)
    ) dut_a (
        .clk(clk), .reset(reset), .key_raw(key_raw), .key_mask(key_mask),
        .key_level(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a),
        .long_pulse(lng_a), .repeat_pulse(rep_a), .any_pressed(any_a)
    );

    keys_debounce_array #(
        .NUM_KEYS(5), .STABLE_CNT(STABLE), .LONG_CNT(LONG), .REPEAT_CNT(REPEAT),
        .ACTIVE_LOW(1), .REPEAT_EN(0)
    ) dut_b (
        .clk(clk), .reset(reset), .key_raw(key_raw), .key_mask(key_mask),
        .key_level(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b),
        .long_pulse(lng_b), .repeat_pulse(rep_b), .any_pressed(any_b)
    );

    assign got_a = {any_a, lvl_a, prs_a, rel_a, lng_a, rep_a};
    assign got_b = {any_b, lvl_b, prs_b, rel_b, lng_b, rep_b};

    // Reference model: pin delay line, run of disagreeing samples, and hold
    // pulses derived from the number of cycles elapsed since the press commit.
    logic [4:0] sy1, sy2, e_lvl, e_prs, e_rel, e_lng, e_rep;
    logic       e_any;
    int         run[5];
    int         held[5];
    bit         holding[5];

    function automatic logic s_of(input int k);
        return ~sy2[k];
    endfunction

    function automatic bit m_commit(input int k);
        return (s_of(k) != e_lvl[k]) && (run[k] + 1 == STABLE);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            sy1 <= '1; sy2 <= '1;
            e_lvl <= '0; e_prs <= '0; e_rel <= '0; e_lng <= '0; e_rep <= '0;
            e_any <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                run[k] <= 0; held[k] <= 0; holding[k] <= 1'b0;
            end
        end else begin
            e_any <= |e_lvl;
            sy1   <= key_raw | ~key_mask;
            sy2   <= sy1;
            for (int k = 0; k < 5; k++) begin
                e_prs[k] <= 1'b0; e_rel[k] <= 1'b0; e_lng[k] <= 1'b0; e_rep[k] <= 1'b0;
                if (s_of(k) != e_lvl[k] && !m_commit(k)) run[k] <= run[k] + 1;
                else                                     run[k] <= 0;
                if (m_commit(k)) begin
                    e_lvl[k]   <= s_of(k);
                    e_prs[k]   <= s_of(k);
                    e_rel[k]   <= ~s_of(k);
                    holding[k] <= s_of(k);
                    held[k]    <= 0;
                end else if (holding[k]) begin
                    held[k] <= held[k] + 1;
                    if (held[k] + 1 == LONG) e_lng[k] <= 1'b1;
                    if (held[k] + 1 > LONG && ((held[k] + 1 - LONG) % REPEAT) == 0)
                        e_rep[k] <= 1'b1;
                end
            end
        end
    end

    function automatic logic [25:0] exp_a();
        return {e_any, e_lvl, e_prs, e_rel, e_lng, e_rep};
    endfunction

    function automatic logic [25:0] exp_b();
        return {e_any, e_lvl, e_prs, e_rel, e_lng, 5'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; key_raw = '1; key_mask = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (got_a !== '0 || got_b !== '0)
                $display("FAIL reset_zero got_a=%h got_b=%h want=0", got_a, got_b);
            else passed++;
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (got_a !== exp_a() || got_b !== exp_b())
                $display("FAIL reset_idle got_a=%h want=%h got_b=%h want=%h", got_a, exp_a(), got_b, exp_b());
            else passed++;
        end
    endtask

    task automatic test_press_latency();
        key_raw[0] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (got_a !== exp_a() || got_b !== exp_b())
                $display("FAIL press_model i=%0d got_a=%h want=%h got_b=%h want=%h", i, got_a, exp_a(), got_b, exp_b());
            else passed++;
            total++;
            if (prs_a[0] !== (i == 6) || lvl_a[0] !== (i >= 6))
                $display("FAIL press_latency i=%0d got prs=%b lvl=%b want prs=%b lvl=%b", i, prs_a[0], lvl_a[0], i == 6, i >= 6);
            else passed++;
        end
        key_raw[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (got_a !== exp_a() || rel_a[0] !== (i == 6))
                $display("FAIL release_latency i=%0d got=%h want=%h", i, got_a, exp_a());
            else passed++;
        end
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 4; i++) begin
                key_raw[1] = (i == 3);
                tick();
                total++;
                if (got_a !== exp_a() || lvl_a[1] !== 1'b0 || prs_a[1] !== 1'b0)
                    $display("FAIL glitch r=%0d got=%h want=%h", r, got_a, exp_a());
                else passed++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (got_a !== exp_a() || got_b !== exp_b())
                $display("FAIL glitch_tail got_a=%h want=%h got_b=%h want=%h", got_a, exp_a(), got_b, exp_b());
            else passed++;
        end
    endtask

    task automatic test_long_repeat();
        int w;
        key_raw[2] = 1'b0;
        w = 0;
        while (w < 10 && prs_a[2] !== 1'b1) begin
            tick();
            w++;
        end
        total++;
        if (prs_a[2] !== 1'b1) $display("FAIL long_press_timeout got=%b want=1", prs_a[2]);
        else passed++;
        for (int j = 1; j <= 60; j++) begin
            tick();
            total++;
            if (got_a !== exp_a() || got_b !== exp_b())
                $display("FAIL long_model j=%0d got_a=%h want=%h got_b=%h want=%h", j, got_a, exp_a(), got_b, exp_b());
            else passed++;
            total++;
            if (lng_a[2] !== (j == LONG) || lng_b[2] !== (j == LONG) ||
                rep_a[2] !== (j > LONG && (j - LONG) % REPEAT == 0) || rep_b[2] !== 1'b0)
                $display("FAIL long_repeat j=%0d got la=%b ra=%b lb=%b rb=%b", j, lng_a[2], rep_a[2], lng_b[2], rep_b[2]);
            else passed++;
        end
        key_raw[2] = 1'b1;
        for (int m = 1; m <= 12; m++) begin
            tick();
            total++;
            if (got_a !== exp_a() || rel_a[2] !== (m == 6) ||
                (m > 1 && rep_a[2] !== 1'b0) || got_b !== exp_b())
                $display("FAIL long_release m=%0d got_a=%h want=%h", m, got_a, exp_a());
            else passed++;
        end
    endtask

    task automatic test_reset_long();
        key_raw[3] = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            total++;
            if (got_a !== exp_a() || got_b !== exp_b())
                $display("FAIL rlong_pre i=%0d got_a=%h want=%h", i, got_a, exp_a());
            else passed++;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (got_a !== '0 || got_b !== '0)
                $display("FAIL rlong_in_reset got_a=%h got_b=%h want=0", got_a, got_b);
            else passed++;
        end
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (got_a !== exp_a() || prs_a[3] !== (i == 6) || lvl_a[3] !== (i >= 6))
                $display("FAIL rlong_repress i=%0d got=%h want=%h", i, got_a, exp_a());
            else passed++;
        end
        key_raw[3] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_mask_simultaneous();
        key_raw[0] = 1'b0; key_raw[4] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if (got_a !== exp_a() || {prs_a[4], prs_a[0]} !== {2{i == 6}})
                $display("FAIL mask_press i=%0d got=%h want=%h", i, got_a, exp_a());
            else passed++;
        end
        key_mask[4] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (got_a !== exp_a() || rel_a[4] !== (i == 6) || lvl_a[0] !== 1'b1 || rel_a[0] !== 1'b0)
                $display("FAIL mask_release i=%0d got=%h want=%h", i, got_a, exp_a());
            else passed++;
        end
        key_raw[0] = 1'b1; key_raw[4] = 1'b1; key_mask[4] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (got_a !== exp_a() || got_b !== exp_b())
                $display("FAIL mask_tail got_a=%h want=%h", got_a, exp_a());
            else passed++;
        end
    endtask

    task automatic test_random();
        int idx;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 5; k++)
                if ($urandom_range(0, 11) == 0) key_raw[k] = ~key_raw[k];
            if ($urandom_range(0, 149) == 0) begin
                idx = $urandom_range(0, 4);
                key_mask[idx] = ~key_mask[idx];
            end
            reset = ($urandom_range(0, 399) == 0);
            tick();
            total++;
            if (got_a !== exp_a() || got_b !== exp_b())
                $display("FAIL random c=%0d got_a=%h want=%h got_b=%h want=%h", c, got_a, exp_a(), got_b, exp_b());
            else passed++;
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_long_repeat();
        test_reset_long();
        test_mask_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
